// File: rtl/prog_clock_divider_if.sv
// Configuration write channel for prog_clock_divider: a valid/ready request
// carrying a channel index and a new high/low phase-length pair.
interface prog_clock_divider_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) ();
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_low;

  modport master (
    output cfg_valid, cfg_ch, cfg_high, cfg_low,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_high, cfg_low,
    output cfg_ready
  );
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with independent high/low phase
// lengths and glitch-free shadow reconfiguration at period boundaries.
module prog_clock_divider #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int DEF_HIGH = 3,
  parameter int DEF_LOW  = 3
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic [NUM_CH-1:0]  en,
  prog_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0]  clk_out,
  output logic [NUM_CH-1:0]  rise_tick,
  output logic [NUM_CH-1:0]  pending
);
  localparam int               CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_LOW);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0]  act_high [NUM_CH];
  logic [CNT_W-1:0]  act_low  [NUM_CH];
  logic [CNT_W-1:0]  shd_high [NUM_CH];
  logic [CNT_W-1:0]  shd_low  [NUM_CH];
  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [NUM_CH-1:0] run_q;
  logic [NUM_CH-1:0] wr_hit;
  logic              ready_c;

  // A programmed length of zero behaves as a one-cycle phase.
  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
    return (len == '0) ? ONE : len;
  endfunction

  // Out-of-range channel indices never match, so such writes are accepted and dropped.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ready_c = 1'b1;
    wr_hit  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        if (pending[i]) ready_c = 1'b0;
        wr_hit[i] = cfg.cfg_valid && !pending[i];
      end
    end
  end

  assign cfg.cfg_ready = ready_c;

  // clk_out doubles as the phase bit: 1 = high phase, 0 = low phase.
  // NOTE: sequential state uses non-blocking assignments so every channel sees pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-channel length arrays are reset because their reset value is functional (DEF_HIGH/DEF_LOW).
      for (int i = 0; i < NUM_CH; i++) begin
        act_high[i] <= DEF_H;
        act_low[i]  <= DEF_L;
        shd_high[i] <= DEF_H;
        shd_low[i]  <= DEF_L;
        cnt[i]      <= '0;
      end
      run_q     <= '0;
      clk_out   <= '0;
      rise_tick <= '0;
      pending   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        rise_tick[i] <= 1'b0;
        run_q[i]     <= en[i];

        // A write can only hit a channel whose pending flag is clear, so it never collides with the apply below.
        if (wr_hit[i]) begin
          shd_high[i] <= cfg.cfg_high;
          shd_low[i]  <= cfg.cfg_low;
          pending[i]  <= 1'b1;
        end

        if (!en[i]) begin
          clk_out[i] <= 1'b0;
          cnt[i]     <= '0;
          if (pending[i]) begin
            act_high[i] <= shd_high[i];
            act_low[i]  <= shd_low[i];
            pending[i]  <= 1'b0;
          end
        end else if (!run_q[i] ||
                     (!clk_out[i] && cnt[i] == eff_len(act_low[i]) - ONE)) begin
          clk_out[i]   <= 1'b1;
          rise_tick[i] <= 1'b1;
          cnt[i]       <= '0;
          if (pending[i]) begin
            act_high[i] <= shd_high[i];
            act_low[i]  <= shd_low[i];
            pending[i]  <= 1'b0;
          end
        end else if (clk_out[i] && cnt[i] == eff_len(act_high[i]) - ONE) begin
          clk_out[i] <= 1'b0;
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: a period-position model is
// compared every cycle, with hand-written waveform strings pinning key scenarios.
module tb_prog_clock_divider;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] clk_out, rise_tick, pending;

  prog_clock_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

  prog_clock_divider #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_HIGH(3), .DEF_LOW(3)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .cfg      (cfg_if),
    .clk_out  (clk_out),
    .rise_tick(rise_tick),
    .pending  (pending)
  );

  always #5 clk_in = ~clk_in;

  int vectors     = 0;
  int miscompares = 0;

  // Model: each running channel is described by its position within the period.
  bit m_run  [NUM_CH];
  int m_pos  [NUM_CH];
  int m_h    [NUM_CH];
  int m_l    [NUM_CH];
  int m_sh   [NUM_CH];
  int m_sl   [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_out  [NUM_CH];
  bit m_tick [NUM_CH];

  function automatic int eff(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_h[i] = 3; m_l[i] = 3; m_sh[i] = 3; m_sl[i] = 3;
      m_pend[i] = 0; m_out[i] = 0; m_tick[i] = 0;
    end
  endtask

  // One clock edge: check cfg_ready beforehand, advance the model, check outputs after.
  task automatic step();
    int  c;
    bit  acc, exp_ready;
    logic [NUM_CH-1:0] e_out, e_tick, e_pend;
    #1;
    c = int'(cfg_if.cfg_ch);
    exp_ready = (c < NUM_CH) ? !m_pend[c] : 1'b1;
    check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(exp_ready));
    acc = cfg_if.cfg_valid && exp_ready && (c < NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      m_tick[i] = 0;
      if (!en[i]) begin
        m_run[i] = 0; m_out[i] = 0;
        if (m_pend[i]) begin m_h[i] = m_sh[i]; m_l[i] = m_sl[i]; m_pend[i] = 0; end
      end else if (!m_run[i] || m_pos[i] + 1 == eff(m_h[i]) + eff(m_l[i])) begin
        if (m_pend[i]) begin m_h[i] = m_sh[i]; m_l[i] = m_sl[i]; m_pend[i] = 0; end
        m_run[i] = 1; m_pos[i] = 0; m_out[i] = 1; m_tick[i] = 1;
      end else begin
        m_pos[i]++;
        m_out[i] = (m_pos[i] < eff(m_h[i]));
      end
      if (acc && c == i) begin
        m_sh[i] = int'(cfg_if.cfg_high); m_sl[i] = int'(cfg_if.cfg_low); m_pend[i] = 1;
      end
      e_out[i] = m_out[i]; e_tick[i] = m_tick[i]; e_pend[i] = m_pend[i];
    end
    @(posedge clk_in);
    #1;
    check("clk_out",   32'(clk_out),   32'(e_out));
    check("rise_tick", 32'(rise_tick), 32'(e_tick));
    check("pending",   32'(pending),   32'(e_pend));
    @(negedge clk_in);
  endtask

  // Step once per character, pinning clk_out[0] (and optionally clk_out[1]) to a literal waveform.
  task automatic run_expect(input string name, input string p0, input string p1 = "");
    for (int k = 0; k < p0.len(); k++) begin
      step();
      check($sformatf("%s_ch0[%0d]", name, k), 32'(clk_out[0]), 32'(p0[k] == "1"));
      if (p1.len() > k)
        check($sformatf("%s_ch1[%0d]", name, k), 32'(clk_out[1]), 32'(p1[k] == "1"));
    end
  endtask

  task automatic cfg_write(input int ch, input int hi, input int lo);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_high  = 8'(hi);
    cfg_if.cfg_low   = 8'(lo);
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 3'b001;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_high  = '0;
    cfg_if.cfg_low   = '0;
    model_reset();
    repeat (2) @(negedge clk_in);
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_tick",    32'(rise_tick), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    rst_n = 1'b1;

    // Defaults 3/3 from reset release
    run_expect("defaults", "1110001110001");
    check("first_tick", 32'(rise_tick), 32'h1);

    // Shadow write mid-high: current period finishes 3/3, then 2/5
    run_expect("mid", "1");
    cfg_write(0, 2, 5);
    check("wr_hold_out", 32'(clk_out[0]), 32'h1);
    check("wr_pend",     32'(pending[0]), 32'h1);
    #1 check("wr_ready_low", 32'(cfg_if.cfg_ready), 32'h0);
    run_expect("stretch_a", "000");
    check("pend_held", 32'(pending[0]), 32'h1);
    run_expect("stretch_b", "11000001");
    check("pend_clear", 32'(pending[0]), 32'h0);

    // Zero lengths behave as 1/1
    cfg_write(0, 0, 0);
    check("zero_wr_out", 32'(clk_out[0]), 32'h1);
    run_expect("zero", "0000010101");

    // Enable dropped in the first high cycle, then reasserted
    cfg_write(0, 3, 3);
    check("r35_wr_out", 32'(clk_out[0]), 32'h0);
    step();
    check("r35_rise", 32'(clk_out[0]), 32'h1);
    en[0] = 1'b0;
    step();
    check("r35_drop_out",  32'(clk_out[0]),   32'h0);
    check("r35_drop_tick", 32'(rise_tick[0]), 32'h0);
    run_expect("off", "000");
    en[0] = 1'b1;
    step();
    check("r35_re_out",  32'(clk_out[0]),   32'h1);
    check("r35_re_tick", 32'(rise_tick[0]), 32'h1);
    run_expect("resume", "110001");

    // Asynchronous reset between edges during a high phase with a write pending
    cfg_write(0, 5, 5);
    check("r36_pre_out",  32'(clk_out[0]), 32'h1);
    check("r36_pre_pend", 32'(pending[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("r36_async_out",  32'(clk_out),   32'h0);
    check("r36_async_tick", 32'(rise_tick), 32'h0);
    check("r36_async_pend", 32'(pending),   32'h0);
    model_reset();
    repeat (2) @(negedge clk_in);
    check("r36_hold_out", 32'(clk_out), 32'h0);
    rst_n = 1'b1;
    run_expect("after_rst", "1110001");

    // Two channels started together: 1/1 and 4/2; out-of-range write dropped
    en = 3'b000;
    step();
    cfg_write(0, 1, 1);
    cfg_write(1, 4, 2);
    cfg_if.cfg_ch = 2'd3;
    #1 check("ch3_ready", 32'(cfg_if.cfg_ready), 32'h1);
    cfg_write(3, 9, 9);
    check("ch3_no_pend", 32'(pending), 32'h0);
    step();
    en = 3'b011;
    run_expect("pair", "1010101010101", "1111001111001");
    check("pair_tick", 32'(rise_tick), 32'h3);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      cfg_if.cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_ch    = 2'($urandom_range(0, 3));
      cfg_if.cfg_high  = 8'($urandom_range(0, 6));
      cfg_if.cfg_low   = 8'($urandom_range(0, 6));
      step();
    end
    cfg_if.cfg_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
